// File: rtl/rr_load_arbiter.sv
// rr_load_arbiter: round-robin arbiter that loads one winner's data into a
// shared output register q and holds q_valid for HOLD_CYCLES cycles per grant.
module rr_load_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = 8,
  parameter  int HOLD_CYCLES = 2,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid,
  output logic [ID_W-1:0]           gnt_id,
  output logic                      busy
);

  localparam int CNT_W = 8;

  if (NUM_REQ < 2 || NUM_REQ > 16 || HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_params
    $error("rr_load_arbiter: NUM_REQ must be 2..16 and HOLD_CYCLES 1..255");
  end

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                q_valid_q, q_valid_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;

  logic                found;
  logic [ID_W-1:0]     win;

  // Winner search: first set req above last, else lowest set req at or below last (wrap).
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i > 32'(last_q))) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i <= 32'(last_q))) begin
        found = 1'b1;
        win   = ID_W'(i);
      end
    end
  end

  // Next-state logic: grant from IDLE, count down the hold window in HOLD.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_id_d  = gnt_id_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    ack_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (en && found) begin
          q_d       = data[win*DATA_W +: DATA_W];
          ack_d     = NUM_REQ'(1) << win;
          gnt_id_d  = win;
          last_d    = win;
          q_valid_d = 1'b1;
          cnt_d     = CNT_W'(HOLD_CYCLES - 1);
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          q_valid_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // State register with synchronous reset; pointer resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= ID_W'(NUM_REQ - 1);
      gnt_id_q  <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_id_q  <= gnt_id_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      ack_q     <= ack_d;
    end
  end

  assign ack     = ack_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q == HOLD);

endmodule

// File: tb/tb_rr_load_arbiter.sv
// Scoreboard bench for rr_load_arbiter: stimulus pushes expected grants,
// a negedge monitor pops and compares whenever an ack pulse appears.
module tb_rr_load_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int HOLD    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack;
  logic [7:0]  q;
  logic        q_valid;
  logic [1:0]  gnt_id;
  logic        busy;

  rr_load_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .data(data),
    .ack(ack), .q(q), .q_valid(q_valid), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         id;
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   run    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] d, input int at);
    exp_t e;
    e.id = id;
    e.d  = d;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // One grant from IDLE: expect winner id at the next edge, then release req.
  task automatic grant_once(input logic [3:0] r, input int id, input logic [7:0] d);
    push_exp(id, d, cyc + 1);
    req = r;
    tick(1);
    req = 4'b0000;
    wait_drain(10);
    wait_idle(10);
  endtask

  // Monitor: compare each ack pulse to the scoreboard, and track q_valid run length.
  always @(negedge clk) begin
    exp_t e;
    if (ack !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", ack, 0);
      end else begin
        e = sb.pop_front();
        chk("ack", ack, 32'(1) << e.id);
        chk("q", q, e.d);
        chk("gnt_id", gnt_id, e.id);
        chk("q_valid_at_grant", q_valid, 1);
        if (e.at != 0) chk("grant_cycle", cyc, e.at);
      end
    end
    if (!reset) chk("busy_eq_q_valid", busy, q_valid);
    if (reset) run = 0;
    else if (q_valid) run++;
    else if (run > 0) begin
      chk("q_valid_len", run, HOLD);
      run = 0;
    end
  end

  initial begin
    int c;
    reset = 1'b1;
    en    = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 4; i++) data[i*8 +: 8] = 8'h10 + 8'(i);

    // Reset held two cycles with all requests up
    tick(2);
    chk("rst_ack", ack, 0);
    chk("rst_q", q, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt_id", gnt_id, 0);

    // Release: rotation 0,1,2,3,0 every HOLD+1 cycles
    reset = 1'b0;
    c = cyc;
    push_exp(0, 8'h10, c + 1);
    push_exp(1, 8'h11, c + 4);
    push_exp(2, 8'h12, c + 7);
    push_exp(3, 8'h13, c + 10);
    push_exp(0, 8'h10, c + 13);
    wait_drain(60);
    req = 4'b0000;
    wait_idle(10);

    // Single grant to requester 2, q retained afterwards
    data[23:16] = 8'hA5;
    grant_once(4'b0100, 2, 8'hA5);
    chk("q_retained", q, 8'hA5);
    chk("q_valid_low_after", q_valid, 0);

    // Wrap and skip from last=2
    grant_once(4'b0011, 0, 8'h10);
    grant_once(4'b0010, 1, 8'h11);
    grant_once(4'b1001, 3, 8'h13);

    // Enable gating
    en  = 1'b0;
    req = 4'b0001;
    repeat (5) begin
      tick(1);
      chk("gated_busy", busy, 0);
      chk("gated_ack", ack, 0);
    end
    en = 1'b1;
    c  = cyc;
    push_exp(0, 8'h10, c + 1);
    tick(1);
    en = 1'b0;
    wait_drain(10);
    wait_idle(10);
    repeat (3) begin
      tick(1);
      chk("gated_idle_busy", busy, 0);
    end
    en = 1'b1;
    c  = cyc;
    push_exp(0, 8'h10, c + 1);
    tick(1);
    req = 4'b0000;
    wait_drain(10);
    wait_idle(10);

    // Reset in the first HOLD cycle after granting requester 3
    req = 4'b1000;
    c   = cyc;
    push_exp(3, 8'h13, c + 1);
    tick(1);
    reset = 1'b1;
    req   = 4'b0000;
    tick(1);
    chk("midhold_q_valid", q_valid, 0);
    chk("midhold_q", q, 0);
    chk("midhold_busy", busy, 0);
    chk("midhold_gnt_id", gnt_id, 0);
    chk("midhold_ack", ack, 0);
    reset = 1'b0;
    grant_once(4'b1000, 3, 8'h13);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    grant_once(4'b1001, 0, 8'h10);

    tick(5);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
